mmio_io_responder: RTL and testbench
====================================

Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder on the data-memory side of the CPU; it is the target of the MEM-stage I/O accesses.
- Decodes I/O addresses and owns the LED and 7-segment registers; drives the 8-digit multiplexed 7-segment display.
- Serves switch reads through a blocking confirm-button handshake: the core is stalled until the user presses and releases the confirm button.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive stable synchronised samples needed to change the debounced button level (≥2).
- SCAN_CYCLES, 100000, clk cycles each display digit stays selected (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- io_read  in  1  MEM-stage I/O read request.
- io_write  in  1  MEM-stage I/O write request.
- io_addr  in  32  byte address of the access.
- io_wdata  in  32  write data.
- io_rdata  out  32  read data; combinational.
- io_stall  out  1  core must hold the current access while high; combinational.
- switch  in  16  raw board switches.
- confirm_btn  in  1  raw asynchronous push button, active-high.
- led  out  16  LED register.
- seg_out  out  8  segments, active-high; bit7=a … bit1=g, bit0=dp (dp always 0).
- tub_sel  out  8  digit select, one-hot, active-high; bit i selects digit i.

Behaviour:
- Reset values:
  - led=0, SEG register=0, scan index=0, scan counter=0.
  - tub_sel=8'h01, seg_out=8'hFC (glyph "0").
  - FSM=IDLE, debounced button=0, switch latch=0.
  - io_rdata=0, io_stall=0.
- Decode: an access is mapped only when io_addr[31:8]==24'hFFFFFC. Offsets:
  - 0x60 LED: R/W; write takes io_wdata[15:0].
  - 0x64 SEG: R/W, 32 bits.
  - 0x70 SW_WAIT: read-only, handshake.
  - 0x74 SW_NOW: read-only; returns {16'b0, switch} with no handshake.
- Unmapped accesses and writes to read-only offsets: read returns 0, write ignored, no stall.
- Writes commit at the clk edge on which io_write=1. io_read and io_write both high is treated as a write only.
- Reads of LED, SEG and SW_NOW: zero latency, io_rdata valid in the same cycle, io_stall=0.
- Button path: 2-FF synchroniser, then debouncer. The debounced level flips after DEBOUNCE_CYCLES consecutive synchronised samples that differ from the current level; any matching sample clears the counter.
- SW_WAIT FSM (req = io_read & ~io_write & addr==0x70):
  - IDLE: req → WAIT_PRESS.
  - WAIT_PRESS: debounced=1 → capture switch into latch, go to WAIT_RELEASE.
  - WAIT_RELEASE: debounced=0 → DONE.
  - DONE: unconditional → IDLE. Exactly one cycle.
  - In WAIT_PRESS/WAIT_RELEASE, if req drops → IDLE and the latch is discarded.
- io_stall = req & (state != DONE). io_rdata = {16'b0, latch} only in DONE.
- A button already held when req arrives is accepted: the debounced level is already 1, so the FSM goes straight through WAIT_PRESS.
- Scan: the counter counts 0..SCAN_CYCLES-1. On wrap, the index increments mod 8 (7→0).
- tub_sel = 1 << index. seg_out = hex glyph of SEG[4*index+3 : 4*index]; digits 0–F map to standard 7-segment patterns.
- Reset mid-handshake: everything returns to reset values immediately; io_stall drops asynchronously.

Decomposition:
- Package mmio_io_pkg: address base and offset constants, FSM state enum (IDLE, WAIT_PRESS, WAIT_RELEASE, DONE), 16-entry hex→segment constant table.
- Sub-module btn_debounce: synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES, output is the debounced level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SCAN_CYCLES=2.
- Write 0xFFFFFC60 with 0x0001_A5A5 → led=16'hA5A5 next edge. Read 0xFFFFFC60 → io_rdata=0x0000A5A5, io_stall=0.
- Write SEG=0x89ABCDEF → tub_sel steps 01,02,04…80,01, changing every 2 cycles. seg_out at index0 is the glyph for F (8'h8E); at index7 it is the glyph for 8 (8'hFE).
- Hold read of 0xFFFFFC70 with switch=16'h1234:
  - Before any button press: io_stall=1 for ≥20 cycles.
  - Press button 10 cycles, then release: io_stall stays 1 through release debounce.
  - Then exactly one cycle with io_stall=0 and io_rdata=0x00001234.
- Switch changed to 16'h5678 after press but before release → returned value stays 0x00001234.
- Button glitch of 2 cycles high while in WAIT_PRESS → no state change, io_stall stays 1.
- Assert rst low during WAIT_RELEASE → io_stall=0 and led=0 immediately; tub_sel=8'h01.
- Read 0xFFFFFC74 → {16'b0,switch} same cycle. Read 0xFFFFFC10 → 0, no stall. Write 0xFFFFFC70 → no register changes.

Source files
------------

// File: rtl/mmio_io_pkg.sv
// Shared constants for the MMIO I/O responder: address map, handshake
// state encoding and the hex-to-7-segment glyph table.
package mmio_io_pkg;

   localparam logic [23:0] IO_BASE     = 24'hFFFFFC;
   localparam logic [7:0]  OFF_LED     = 8'h60;
   localparam logic [7:0]  OFF_SEG     = 8'h64;
   localparam logic [7:0]  OFF_SW_WAIT = 8'h70;
   localparam logic [7:0]  OFF_SW_NOW  = 8'h74;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_WAIT_PRESS   = 2'd1,
      ST_WAIT_RELEASE = 2'd2,
      ST_DONE         = 2'd3
   } sw_state_e;

   // Segment order a..g in bits 7..1, dp (bit 0) never lit. Entry 0 is last.
   localparam logic [15:0][7:0] SEG_LUT = {
      8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E d C
      8'h3E, 8'hEE, 8'hF6, 8'hFE,   // b A 9 8
      8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
      8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
   };

endpackage

// File: rtl/mmio_io_responder_btn_debounce.sv
// Confirm-button conditioning: two-flop synchroniser followed by a
// consecutive-sample debouncer. The level flips only after DEBOUNCE_CYCLES
// synchronised samples in a row disagree with it.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Bring the raw button into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Down-count disagreeing samples; terminal count flips the level.
   always_comb begin
      level_d = level_q;
      cnt_d   = CNT_LOAD;
      if (sync2_q != level_q) begin
         if (cnt_q == '0) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Debounce state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         cnt_q   <= CNT_LOAD;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/mmio_io_responder.sv
// MMIO target for MEM-stage I/O accesses: LED and SEG registers, immediate
// and button-confirmed switch reads, and the multiplexed 8-digit display.
//
// state           | meaning
// ----------------+------------------------------------------------------
// ST_IDLE         | no switch handshake in progress
// ST_WAIT_PRESS   | core stalled, waiting for debounced press
// ST_WAIT_RELEASE | switches latched, waiting for debounced release
// ST_DONE         | one cycle: stall released, latched value on io_rdata
module mmio_io_responder
   import mmio_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int SCAN_CYCLES     = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_read,
   input  logic        io_write,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        io_stall,
   input  logic [15:0] switch,
   input  logic        confirm_btn,
   output logic [15:0] led,
   output logic [7:0]  seg_out,
   output logic [7:0]  tub_sel
);

   localparam int            SW        = $clog2(SCAN_CYCLES + 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

   logic            mapped, rd_only, sw_req, wr_led, wr_seg;
   logic [7:0]      off;
   logic            btn_level;
   logic [15:0]     led_q;
   logic [31:0]     seg_q;
   sw_state_e       state_q, state_d;
   logic [15:0]     latch_q, latch_d;
   logic [SW-1:0]   scan_cnt_q;
   logic [2:0]      scan_idx_q;
   logic [3:0]      digit;

   assign off     = io_addr[7:0];
   assign mapped  = (io_addr[31:8] == IO_BASE);
   // A simultaneous read+write is a write only.
   assign rd_only = io_read & ~io_write & mapped;
   assign sw_req  = rd_only & (off == OFF_SW_WAIT);
   assign wr_led  = io_write & mapped & (off == OFF_LED);
   assign wr_seg  = io_write & mapped & (off == OFF_SEG);

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk     (clk),
      .rst_n   (rst),
      .btn_i   (confirm_btn),
      .level_o (btn_level)
   );

   // Writable registers commit on the edge where io_write is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q <= '0;
         seg_q <= '0;
      end else begin
         if (wr_led) led_q <= io_wdata[15:0];
         if (wr_seg) seg_q <= io_wdata;
      end
   end

   // Switch handshake next state; dropping the request abandons the latch.
   always_comb begin
      state_d = state_q;
      latch_d = latch_q;
      unique case (state_q)
         ST_IDLE: begin
            if (sw_req) state_d = ST_WAIT_PRESS;
         end
         ST_WAIT_PRESS: begin
            if (!sw_req) begin
               state_d = ST_IDLE;
               latch_d = '0;
            end else if (btn_level) begin
               latch_d = switch;
               state_d = ST_WAIT_RELEASE;
            end
         end
         ST_WAIT_RELEASE: begin
            if (!sw_req) begin
               state_d = ST_IDLE;
               latch_d = '0;
            end else if (!btn_level) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handshake state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         latch_q <= '0;
      end else begin
         state_q <= state_d;
         latch_q <= latch_d;
      end
   end

   // Read mux and stall; both gated by reset so they drop asynchronously.
   always_comb begin
      io_rdata = '0;
      io_stall = rst & sw_req & (state_q != ST_DONE);
      if (rst && rd_only) begin
         unique case (off)
            OFF_LED:     io_rdata = {16'h0000, led_q};
            OFF_SEG:     io_rdata = seg_q;
            OFF_SW_NOW:  io_rdata = {16'h0000, switch};
            OFF_SW_WAIT: io_rdata = (state_q == ST_DONE) ? {16'h0000, latch_q} : 32'h0;
            default:     io_rdata = '0;
         endcase
      end
   end

   // Display scan: dwell SCAN_CYCLES clocks per digit, then advance mod 8.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
      end else if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_q <= '0;
         scan_idx_q <= scan_idx_q + 3'd1;
      end else begin
         scan_cnt_q <= scan_cnt_q + 1'b1;
      end
   end

   assign digit   = seg_q[{scan_idx_q, 2'b00} +: 4];
   assign seg_out = SEG_LUT[digit];
   assign tub_sel = 8'h01 << scan_idx_q;
   assign led     = led_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Randomised and directed bench for mmio_io_responder against a behavioural
// model of the register map, the switch handshake and the display scan.
module tb_mmio_io_responder;

   localparam int DEB  = 4;
   localparam int SCAN = 2;
   localparam logic [23:0] BASE = 24'hFFFFFC;
   localparam int P_IDLE = 0, P_PRESS = 1, P_RELEASE = 2, P_DONE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        io_read = 1'b0, io_write = 1'b0;
   logic [31:0] io_addr = '0, io_wdata = '0;
   logic [31:0] io_rdata;
   logic        io_stall;
   logic [15:0] switch = '0;
   logic        confirm_btn = 1'b0;
   logic [15:0] led;
   logic [7:0]  seg_out, tub_sel;

   always #5 clk = ~clk;

   mmio_io_responder #(.DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
      .clk(clk), .rst(rst), .io_read(io_read), .io_write(io_write),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
      .io_stall(io_stall), .switch(switch), .confirm_btn(confirm_btn),
      .led(led), .seg_out(seg_out), .tub_sel(tub_sel)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   // Behavioural model state
   logic [15:0] led_m;
   logic [31:0] seg_m;
   int          edges;
   bit          hist[$];
   bit          deb_m;
   int          ph;
   logic [15:0] latch_m;

   logic        obs_stall;
   logic [31:0] obs_rdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic bit model_req();
      return io_read && !io_write && io_addr[31:8] == BASE && io_addr[7:0] == 8'h70;
   endfunction

   function automatic logic [31:0] model_rdata();
      if (!io_read || io_write || io_addr[31:8] != BASE) return 32'h0;
      case (io_addr[7:0])
         8'h60:   return {16'h0, led_m};
         8'h64:   return seg_m;
         8'h74:   return {16'h0, switch};
         8'h70:   return (ph == P_DONE) ? {16'h0, latch_m} : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit raw_at(input int k);
      return (k >= 0 && k < hist.size()) ? hist[k] : 1'b0;
   endfunction

   task automatic model_edge();
      bit req, flip;
      req = model_req();
      if (io_write && io_addr[31:8] == BASE) begin
         if (io_addr[7:0] == 8'h60) led_m = io_wdata[15:0];
         if (io_addr[7:0] == 8'h64) seg_m = io_wdata;
      end
      case (ph)
         P_IDLE:    if (req) ph = P_PRESS;
         P_PRESS:   if (!req) begin ph = P_IDLE; latch_m = '0; end
                    else if (deb_m) begin latch_m = switch; ph = P_RELEASE; end
         P_RELEASE: if (!req) begin ph = P_IDLE; latch_m = '0; end
                    else if (!deb_m) ph = P_DONE;
         default:   ph = P_IDLE;
      endcase
      // button seen by the debouncer lags the pin by two clocks
      hist.push_back(confirm_btn);
      flip = 1'b1;
      for (int j = 2; j < 2 + DEB; j++)
         if (raw_at(edges - j) == deb_m) flip = 1'b0;
      if (flip) deb_m = !deb_m;
      edges++;
   endtask

   task automatic cycle();
      int idx;
      logic [7:0] tub_w;
      @(negedge clk);
      idx = (edges / SCAN) % 8;
      tub_w = 8'h01 << idx;
      obs_stall = io_stall;
      obs_rdata = io_rdata;
      chk("rdata", io_rdata, model_rdata());
      chk("stall", 32'(io_stall), 32'(model_req() && ph != P_DONE));
      chk("led", 32'(led), 32'(led_m));
      chk("tub_sel", 32'(tub_sel), 32'(tub_w));
      chk("seg_out", 32'(seg_out), 32'(glyph[seg_m[4*idx +: 4]]));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_stall", 32'(io_stall), 32'h0);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_tub", 32'(tub_sel), 32'h01);
      chk("rst_seg", 32'(seg_out), 32'hFC);
      chk("rst_rdata", io_rdata, 32'h0);
      led_m = '0; seg_m = '0; edges = 0; hist.delete();
      deb_m = 1'b0; ph = P_IDLE; latch_m = '0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic set_idle();
      io_read = 1'b0; io_write = 1'b0; io_addr = '0; io_wdata = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      io_read = 1'b0; io_write = 1'b1; io_addr = a; io_wdata = d;
      cycle();
      set_idle();
   endtask

   task automatic rd(input logic [31:0] a);
      io_read = 1'b1; io_write = 1'b0; io_addr = a;
      cycle();
      set_idle();
   endtask

   initial begin
      int stalled;
      bit done;
      logic [31:0] addrs [6];
      addrs = '{32'hFFFFFC60, 32'hFFFFFC64, 32'hFFFFFC70, 32'hFFFFFC74,
                32'hFFFFFC10, 32'h12345660};

      io_read = 1'b1; io_addr = 32'hFFFFFC70;   // request held through reset
      do_reset();
      set_idle();

      // LED write then read back
      wr(32'hFFFFFC60, 32'h0001A5A5);
      chk("led_after_write", 32'(led), 32'h0000A5A5);
      rd(32'hFFFFFC60);
      chk("led_read", obs_rdata, 32'h0000A5A5);

      // SEG write, let the scan run through two full rotations
      wr(32'hFFFFFC64, 32'h89ABCDEF);
      repeat (34) cycle();

      // Blocking switch read with switch change between press and release
      switch = 16'h1234;
      io_read = 1'b1; io_addr = 32'hFFFFFC70;
      stalled = 0;
      repeat (20) begin cycle(); if (obs_stall) stalled++; end
      chk("pre_press_stalled", 32'(stalled), 32'd20);
      confirm_btn = 1'b1;
      repeat (8) cycle();
      switch = 16'h5678;
      repeat (2) cycle();
      confirm_btn = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         cycle();
         if (!obs_stall) done = 1'b1;
      end
      chk("sw_wait_done", 32'(done), 32'h1);
      chk("sw_wait_value", obs_rdata, 32'h00001234);
      cycle();
      chk("post_done_stall", 32'(obs_stall), 32'h1);
      set_idle();
      cycle();

      // Short glitch while waiting for a press
      io_read = 1'b1; io_addr = 32'hFFFFFC70;
      repeat (5) cycle();
      confirm_btn = 1'b1;
      repeat (2) cycle();
      confirm_btn = 1'b0;
      stalled = 0;
      repeat (10) begin cycle(); if (obs_stall) stalled++; end
      chk("glitch_stalled", 32'(stalled), 32'd10);
      set_idle();
      cycle();

      // Reset while waiting for release
      wr(32'hFFFFFC60, 32'h00003C3C);
      io_read = 1'b1; io_addr = 32'hFFFFFC70;
      confirm_btn = 1'b1;
      repeat (9) cycle();
      confirm_btn = 1'b0;
      cycle();
      chk("pre_reset_stall", 32'(obs_stall), 32'h1);
      do_reset();
      set_idle();

      // Immediate switch read, unmapped read, write to read-only offset
      switch = 16'hABCD;
      rd(32'hFFFFFC74);
      chk("sw_now", obs_rdata, 32'h0000ABCD);
      rd(32'hFFFFFC10);
      chk("unmapped_rd", obs_rdata, 32'h0);
      chk("unmapped_stall", 32'(obs_stall), 32'h0);
      wr(32'hFFFFFC70, 32'hFFFFFFFF);
      rd(32'hFFFFFC60);
      rd(32'hFFFFFC64);

      // Random runs of held operations
      for (int n = 0; n < 120; n++) begin
         int len, op;
         io_addr  = addrs[$urandom_range(0, 5)];
         op       = $urandom_range(0, 3);
         io_read  = (op == 1 || op == 3);
         io_write = (op == 2 || op == 3);
         io_wdata = $urandom;
         len = $urandom_range(1, 15);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 7) == 0) confirm_btn = ~confirm_btn;
            if ($urandom_range(0, 5) == 0) switch = 16'($urandom);
            cycle();
         end
      end
      set_idle();
      confirm_btn = 1'b0;
      repeat (4) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
